uart_fifo_param: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 4x8 UART buffer. One instance sits on the RX path (receiver -> CSR read) and one on the TX path (CSR write -> transmitter).
- Adds generic width and depth, a full-range occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow flags, and a flush.
- Has defined simultaneous push/pop behaviour at every fill level.

---
 rtl/uart_fifo_param.sv | 134 +++++++++++++
 tb/tb_uart_fifo_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART RX and TX paths.
// Features: first-word fall-through read, full-range occupancy count,
// almost-full and almost-empty thresholds, sticky overflow/underflow flags
// and a synchronous flush. One simultaneous push and pop is defined at every
// fill level.
module uart_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       err_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Thresholds cast once to the count width so the decodes compare like widths.
  localparam logic [AW:0] DepthCnt  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfullCnt  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AemptyCnt = (AW+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              empty;
  logic              full;
  logic              push_acc;
  logic              pop_acc;
  logic              ovf_evt;
  logic              udf_evt;

  // Status decodes of the stored count.
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == DepthCnt);
  end

  // Accept rules and error events, all on current-cycle state.
  // A pop frees the head slot at the same edge, so a push into a full FIFO is
  // accepted when paired with a pop. Flush suppresses everything.
  always_comb begin
    pop_acc  = pop_i & ~empty & ~flush_i;
    push_acc = push_i & (~full | pop_i) & ~flush_i;
    ovf_evt  = push_i & full & ~pop_i & ~flush_i;
    udf_evt  = pop_i & empty & ~flush_i;
  end

  // Next-state for pointers, count and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap through natural AW-bit overflow (DEPTH is a power of two).
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Clear first so a coincident set event wins.
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && push_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Outputs: fall-through head and count decodes.
  always_comb begin
    data_o         = mem_q[rd_ptr_q];
    cnt_o          = cnt_q;
    empty_o        = empty;
    full_o         = full;
    almost_full_o  = (cnt_q >= AfullCnt);
    almost_empty_o = (cnt_q <= AemptyCnt);
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed self-checking bench for uart_fifo_param: a default 8x16 instance
// and a 12x4 instance with tight thresholds.
module tb_uart_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2
  logic        a_rst, a_flush, a_push, a_pop, a_clr;
  logic [7:0]  a_din, a_dout;
  logic [4:0]  a_cnt;
  logic        a_empty, a_full, a_af, a_ae, a_ovf, a_udf;

  // Instance B: DATA_W=12, DEPTH=4, AFULL_TH=3, AEMPTY_TH=0
  logic        b_rst, b_flush, b_push, b_pop, b_clr;
  logic [11:0] b_din, b_dout;
  logic [2:0]  b_cnt;
  logic        b_empty, b_full, b_af, b_ae, b_ovf, b_udf;

  uart_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2)
  ) u_dut_a (
    .wb_clk_i      (clk),
    .wb_rst_i      (a_rst),
    .flush_i       (a_flush),
    .push_i        (a_push),
    .data_i        (a_din),
    .pop_i         (a_pop),
    .data_o        (a_dout),
    .cnt_o         (a_cnt),
    .empty_o       (a_empty),
    .full_o        (a_full),
    .almost_full_o (a_af),
    .almost_empty_o(a_ae),
    .overflow_o    (a_ovf),
    .underflow_o   (a_udf),
    .err_clr_i     (a_clr)
  );

  uart_fifo_param #(
    .DATA_W(12), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(0)
  ) u_dut_b (
    .wb_clk_i      (clk),
    .wb_rst_i      (b_rst),
    .flush_i       (b_flush),
    .push_i        (b_push),
    .data_i        (b_din),
    .pop_i         (b_pop),
    .data_o        (b_dout),
    .cnt_o         (b_cnt),
    .empty_o       (b_empty),
    .full_o        (b_full),
    .almost_full_o (b_af),
    .almost_empty_o(b_ae),
    .overflow_o    (b_ovf),
    .underflow_o   (b_udf),
    .err_clr_i     (b_clr)
  );

  logic [7:0]  qa[$];
  logic [11:0] qb[$];
  logic [7:0]  da;
  logic [11:0] db;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls on instance A; outputs settle #1 after the edge.
  task automatic a_op(input bit push, input logic [7:0] d, input bit pop,
                      input bit flush = 1'b0, input bit clr = 1'b0, input bit rst = 1'b0);
    a_push = push; a_din = d; a_pop = pop; a_flush = flush; a_clr = clr; a_rst = rst;
    @(posedge clk);
    #1;
    a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_rst = 1'b0;
  endtask

  task automatic b_op(input bit push, input logic [11:0] d, input bit pop,
                      input bit rst = 1'b0);
    b_push = push; b_din = d; b_pop = pop; b_rst = rst;
    @(posedge clk);
    #1;
    b_push = 1'b0; b_pop = 1'b0; b_rst = 1'b0;
  endtask

  task automatic a_pop_chk(input string tag);
    check(tag, 32'(a_dout), 32'(qa[0]));
    a_op(1'b0, 8'h00, 1'b1);
    da = qa.pop_front();
  endtask

  task automatic b_pop_chk(input string tag);
    check(tag, 32'(b_dout), 32'(qb[0]));
    b_op(1'b0, 12'h000, 1'b1);
    db = qb.pop_front();
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = '0;
    a_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    b_op(1'b0, 12'h000, 1'b0, 1'b1);

    // Reset state
    check("a_rst_cnt", 32'(a_cnt), 0);
    check("a_rst_empty", 32'(a_empty), 1);
    check("a_rst_full", 32'(a_full), 0);
    check("a_rst_ae", 32'(a_ae), 1);
    check("a_rst_af", 32'(a_af), 0);
    check("a_rst_ovf", 32'(a_ovf), 0);
    check("a_rst_udf", 32'(a_udf), 0);

    // 1: three pushes, three pops in order
    a_op(1'b1, 8'h11, 1'b0); qa.push_back(8'h11);
    check("s1_lat_data", 32'(a_dout), 32'h11);
    check("s1_cnt1", 32'(a_cnt), 1);
    a_op(1'b1, 8'h22, 1'b0); qa.push_back(8'h22);
    check("s1_ae_at2", 32'(a_ae), 1);
    a_op(1'b1, 8'h33, 1'b0); qa.push_back(8'h33);
    check("s1_cnt3", 32'(a_cnt), 3);
    check("s1_ae_at3", 32'(a_ae), 0);
    check("s1_head", 32'(a_dout), 32'h11);
    a_pop_chk("s1_pop0");
    a_pop_chk("s1_pop1");
    a_pop_chk("s1_pop2");
    check("s1_empty", 32'(a_empty), 1);
    check("s1_cnt0", 32'(a_cnt), 0);

    // 2: fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      a_op(1'b1, 8'(i), 1'b0); qa.push_back(8'(i));
      if (i == 10) check("s2_af_at11", 32'(a_af), 0);
      if (i == 11) check("s2_af_at12", 32'(a_af), 1);
      if (i == 14) check("s2_full_at15", 32'(a_full), 0);
    end
    check("s2_full", 32'(a_full), 1);
    check("s2_cnt16", 32'(a_cnt), 16);
    a_op(1'b1, 8'hAA, 1'b0);
    check("s2_ovf", 32'(a_ovf), 1);
    check("s2_ovf_cnt", 32'(a_cnt), 16);
    check("s2_ovf_head", 32'(a_dout), 32'h00);
    check("s2_udf_clean", 32'(a_udf), 0);
    a_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("s2_clr", 32'(a_ovf), 0);

    // 3: push+pop while full, drain, then streaming across pointer wrap
    a_op(1'b1, 8'h55, 1'b1);
    da = qa.pop_front(); qa.push_back(8'h55);
    check("s3_full_cnt", 32'(a_cnt), 16);
    check("s3_full_head", 32'(a_dout), 32'h01);
    check("s3_no_ovf", 32'(a_ovf), 0);
    for (int i = 0; i < 16; i++) a_pop_chk("s3_drain");
    check("s3_last55", 32'(da), 32'h55);
    check("s3_empty", 32'(a_empty), 1);
    for (int i = 0; i < 8; i++) begin
      a_op(1'b1, 8'(8'h40 + i), 1'b0); qa.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 40; i++) begin
      check("s3_stream", 32'(a_dout), 32'(qa[0]));
      a_op(1'b1, 8'(8'h80 + i), 1'b1);
      da = qa.pop_front(); qa.push_back(8'(8'h80 + i));
    end
    check("s3_stream_cnt", 32'(a_cnt), 8);
    for (int i = 0; i < 8; i++) a_pop_chk("s3_stream_drain");
    check("s3_stream_empty", 32'(a_empty), 1);

    // 4: push+pop on empty, error clear, clear coincident with new underflow
    a_op(1'b1, 8'h77, 1'b1);
    check("s4_cnt", 32'(a_cnt), 1);
    check("s4_udf", 32'(a_udf), 1);
    check("s4_data", 32'(a_dout), 32'h77);
    a_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("s4_clr_udf", 32'(a_udf), 0);
    check("s4_clr_ovf", 32'(a_ovf), 0);
    a_op(1'b0, 8'h00, 1'b1);
    check("s4_pop_empty", 32'(a_empty), 1);
    check("s4_pop_noudf", 32'(a_udf), 0);
    a_op(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("s4_set_wins", 32'(a_udf), 1);
    a_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 5: flush with push asserted
    for (int i = 0; i < 5; i++) a_op(1'b1, 8'(8'hC0 + i), 1'b0);
    check("s5_cnt5", 32'(a_cnt), 5);
    a_op(1'b1, 8'hEE, 1'b0, 1'b1);
    check("s5_flush_cnt", 32'(a_cnt), 0);
    check("s5_flush_empty", 32'(a_empty), 1);
    check("s5_flush_ovf", 32'(a_ovf), 0);
    check("s5_flush_udf", 32'(a_udf), 0);
    a_op(1'b0, 8'h00, 1'b1, 1'b1);
    check("s5_flush_pop_udf", 32'(a_udf), 0);
    a_op(1'b1, 8'h99, 1'b0);
    check("s5_after", 32'(a_dout), 32'h99);
    check("s5_after_cnt", 32'(a_cnt), 1);

    // 6: mid-stream reset with push, flags set beforehand
    a_op(1'b0, 8'h00, 1'b1);
    a_op(1'b0, 8'h00, 1'b1);
    check("s6_udf_pre", 32'(a_udf), 1);
    a_op(1'b1, 8'h01, 1'b0);
    a_op(1'b1, 8'h02, 1'b0);
    a_op(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s6_rst_cnt", 32'(a_cnt), 0);
    check("s6_rst_empty", 32'(a_empty), 1);
    check("s6_rst_udf", 32'(a_udf), 0);
    check("s6_rst_ovf", 32'(a_ovf), 0);

    // Instance B: reset, scenario 1
    check("b_rst_cnt", 32'(b_cnt), 0);
    check("b_rst_ae", 32'(b_ae), 1);
    b_op(1'b1, 12'h111, 1'b0); qb.push_back(12'h111);
    check("b1_ae_at1", 32'(b_ae), 0);
    b_op(1'b1, 12'h222, 1'b0); qb.push_back(12'h222);
    check("b1_af_at2", 32'(b_af), 0);
    b_op(1'b1, 12'h333, 1'b0); qb.push_back(12'h333);
    check("b1_af_at3", 32'(b_af), 1);
    check("b1_cnt3", 32'(b_cnt), 3);
    check("b1_head", 32'(b_dout), 32'h111);
    for (int i = 0; i < 3; i++) b_pop_chk("b1_pop");
    check("b1_empty", 32'(b_empty), 1);

    // B scenario 2: fill, overflow
    for (int i = 0; i < 4; i++) begin
      b_op(1'b1, 12'(12'hA00 + i), 1'b0); qb.push_back(12'(12'hA00 + i));
    end
    check("b2_full", 32'(b_full), 1);
    check("b2_cnt4", 32'(b_cnt), 4);
    b_op(1'b1, 12'hABC, 1'b0);
    check("b2_ovf", 32'(b_ovf), 1);
    check("b2_head", 32'(b_dout), 32'hA00);

    // B scenario 3: push+pop at full, drain, stream across wrap
    b_op(1'b1, 12'h555, 1'b1);
    db = qb.pop_front(); qb.push_back(12'h555);
    check("b3_cnt", 32'(b_cnt), 4);
    check("b3_head", 32'(b_dout), 32'hA01);
    for (int i = 0; i < 4; i++) b_pop_chk("b3_drain");
    check("b3_last555", 32'(db), 32'h555);
    b_op(1'b1, 12'hF00, 1'b0); qb.push_back(12'hF00);
    b_op(1'b1, 12'hF01, 1'b0); qb.push_back(12'hF01);
    for (int i = 0; i < 12; i++) begin
      check("b3_stream", 32'(b_dout), 32'(qb[0]));
      b_op(1'b1, 12'(12'hE00 + i), 1'b1);
      db = qb.pop_front(); qb.push_back(12'(12'hE00 + i));
    end
    for (int i = 0; i < 2; i++) b_pop_chk("b3_stream_drain");
    check("b3_empty", 32'(b_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
